// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the CPU control sequencer and decoders.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_MEM_LD = 3'd4,
        ST_MEM_ST = 3'd5,
        ST_BRANCH = 3'd6,
        ST_JUMP   = 3'd7
    } state_t;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_MEM    = 4'b0100;
    localparam logic [3:0] OP_BCOND  = 4'b1100;
    localparam logic [3:0] OP_CMPI   = 4'b1011;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_CMP   = 4'b1011;

    localparam logic [1:0] PC_SEL_INC  = 2'd0;
    localparam logic [1:0] PC_SEL_DISP = 2'd1;
    localparam logic [1:0] PC_SEL_REG  = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    // Bit positions in the one-hot instruction class vector.
    localparam int NUM_CLS   = 10;
    localparam int CLS_RTYPE = 0;
    localparam int CLS_CMP   = 1;
    localparam int CLS_ITYPE = 2;
    localparam int CLS_CMPI  = 3;
    localparam int CLS_LOAD  = 4;
    localparam int CLS_STOR  = 5;
    localparam int CLS_JAL   = 6;
    localparam int CLS_JCOND = 7;
    localparam int CLS_BCOND = 8;
    localparam int CLS_NOP   = 9;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_control_fsm_classifier.sv
`default_nettype none
// ============================================================================
// Module      : instr_classifier
// Description : Combinational opcode/ext to one-hot instruction class.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_classifier
    import cpu_pkg::*;
(
    input  logic [3:0]         opcode,
    input  logic [3:0]         ext,
    output logic [NUM_CLS-1:0] cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                if (ext == EXT_CMP) cls[CLS_CMP]   = 1'b1;
                else                cls[CLS_RTYPE] = 1'b1;
            end
            OP_MEM: begin
                // Unassigned ext codes under the memory opcode are NOPs.
                case (ext)
                    EXT_LOAD:  cls[CLS_LOAD]  = 1'b1;
                    EXT_STOR:  cls[CLS_STOR]  = 1'b1;
                    EXT_JAL:   cls[CLS_JAL]   = 1'b1;
                    EXT_JCOND: cls[CLS_JCOND] = 1'b1;
                    default:   cls[CLS_NOP]   = 1'b1;
                endcase
            end
            OP_BCOND: cls[CLS_BCOND] = 1'b1;
            OP_CMPI:  cls[CLS_CMPI]  = 1'b1;
            default:  cls[CLS_ITYPE] = 1'b1;
        endcase
    end

endmodule : instr_classifier
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_fsm
// Description : Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr,
    input  logic        mem_rdata_valid,
    input  logic        cond_true,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_load,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        alu_src_imm,
    output logic        psr_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state
);

    localparam state_t RESET_STATE = ST_FETCH;

    state_t               r_state;
    state_t               w_next_state;
    logic [NUM_CLS-1:0]   w_cls;
    logic                 w_imm_op;
    logic                 w_flag_only;
    logic                 w_unused_instr_bits;

    instr_classifier u_classifier (
        .opcode (instr[15:12]),
        .ext    (instr[7:4]),
        .cls    (w_cls)
    );

    // Register fields are consumed by the datapath, not by the sequencer.
    assign w_unused_instr_bits = ^{instr[11:8], instr[3:0]};

    assign w_imm_op    = w_cls[CLS_ITYPE] | w_cls[CLS_CMPI];
    assign w_flag_only = w_cls[CLS_CMP]   | w_cls[CLS_CMPI];
    assign state       = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= RESET_STATE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = PC_SEL_INC;
        alu_src_imm  = 1'b0;
        psr_we       = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = WB_SEL_ALU;

        // Outputs are gated by reset_n so mem_req drops without waiting for a clock.
        if (reset_n) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_rdata_valid) begin
                        ir_load      = 1'b1;
                        pc_en        = 1'b1;
                        pc_sel       = PC_SEL_INC;
                        w_next_state = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_cls[CLS_LOAD])
                        w_next_state = ST_MEM_LD;
                    else if (w_cls[CLS_STOR])
                        w_next_state = ST_MEM_ST;
                    else if (w_cls[CLS_BCOND])
                        w_next_state = ST_BRANCH;
                    else if (w_cls[CLS_JAL] | w_cls[CLS_JCOND])
                        w_next_state = ST_JUMP;
                    else if (w_cls[CLS_RTYPE] | w_cls[CLS_ITYPE] | w_flag_only)
                        w_next_state = ST_EXEC;
                    else
                        w_next_state = ST_FETCH;
                end
                ST_EXEC: begin
                    alu_src_imm  = w_imm_op;
                    psr_we       = 1'b1;
                    w_next_state = w_flag_only ? ST_FETCH : ST_WB;
                end
                ST_WB: begin
                    alu_src_imm  = w_imm_op;
                    reg_we       = 1'b1;
                    wb_sel       = WB_SEL_ALU;
                    w_next_state = ST_FETCH;
                end
                ST_MEM_LD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_rdata_valid) begin
                        reg_we       = 1'b1;
                        wb_sel       = WB_SEL_MEM;
                        w_next_state = ST_FETCH;
                    end
                end
                ST_MEM_ST: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_rdata_valid) w_next_state = ST_FETCH;
                end
                ST_BRANCH: begin
                    pc_sel       = PC_SEL_DISP;
                    pc_en        = cond_true;
                    w_next_state = ST_FETCH;
                end
                ST_JUMP: begin
                    // Link value is the already-incremented PC; the target comes
                    // from the register read before the link write lands.
                    pc_sel = PC_SEL_REG;
                    if (w_cls[CLS_JAL]) begin
                        reg_we = 1'b1;
                        wb_sel = WB_SEL_LINK;
                        pc_en  = 1'b1;
                    end else begin
                        pc_en  = cond_true;
                    end
                    w_next_state = ST_FETCH;
                end
                default: w_next_state = RESET_STATE;
            endcase
        end
    end

endmodule : cpu_control_fsm
`default_nettype wire
